// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared sizes, FSM encoding and the round-robin pick helper
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan req from ptr upward modulo N_REQ; walking offsets high-to-low lets
    // the smallest offset (closest to ptr) overwrite and win.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] k;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_sel.sv
// mux4_sel: combinational 4:1 single-bit mux
// Ports: s0 (select MSB), s1 (select LSB), i0..i3 data inputs, y selected bit.
module mux4_sel (
    input  logic s0,
    input  logic s1,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic y
);

    assign y = s0 ? (s1 ? i3 : i2) : (s1 ? i1 : i0);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4:1 mux among four 1-bit sources
// Ports: clk, rst_n (async active-low), req[3:0] requests, din[3:0] source bits,
//        out_ready consumer accept; gnt[3:0] one-hot grant, s0/s1 registered
//        mux select, y selected bit, y_valid handshake qualifier.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic             s0,
    output logic             s1,
    output logic             y,
    output logic             y_valid
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             granted;
    logic             xfer;
    logic             rel;
    pick_t            pick;

    assign granted = state_q == GRANT;
    assign y_valid = granted & req[sel_q];
    assign xfer    = y_valid & out_ready;
    assign rel     = granted & (~req[sel_q] | (xfer & (cnt_q == CNT_W'(HOLD_MAX - 1))));

    // On release the scan starts just past the current owner, so the owner is
    // considered last: others win first, and a lone owner re-wins (self-wrap).
    assign pick = rr_pick(req, granted ? sel_q + SEL_W'(1) : ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (granted && !rel) begin
            cnt_d = xfer ? cnt_q + CNT_W'(1) : cnt_q;
        end else begin
            ptr_d   = granted ? sel_q + SEL_W'(1) : ptr_q;
            cnt_d   = '0;
            state_d = pick.found ? GRANT : IDLE;
            gnt_d   = pick.found ? N_REQ'(1) << pick.idx : '0;
            sel_d   = pick.found ? pick.idx : sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt = gnt_q;
    assign s0  = sel_q[1];
    assign s1  = sel_q[0];

    mux4_sel u_mux (
        .s0 (s0),
        .s1 (s1),
        .i0 (din[0]),
        .i1 (din[1]),
        .i2 (din[2]),
        .i3 (din[3]),
        .y  (y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic       out_ready;
    logic [3:0] gnt, gnt1;
    logic       s0, s1, y, y_valid;
    logic       s01, s11, y1, yv1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
        .gnt(gnt), .s0(s0), .s1(s1), .y(y), .y_valid(y_valid)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
        .gnt(gnt1), .s0(s01), .s1(s11), .y(y1), .y_valid(yv1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [3:0] r, input logic rdy);
        rst_n = 1'b0;
        tick();
        req       = r;
        out_ready = rdy;
        rst_n     = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1010;
        din       = 4'b0001;
        out_ready = 1'b0;
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel", {2'b00, s0, s1}, 4'b0000);
        chk("rst_yv", {3'b000, y_valid}, 4'b0000);
        chk("rst_y", {3'b000, y}, 4'b0001);
        tick();
        chk("rst_hold_gnt", gnt, 4'b0000);
        rst_n = 1'b1;
        tick();
        chk("first_gnt", gnt, 4'b0010);
        chk("first_sel", {2'b00, s0, s1}, 4'b0001);
        chk("first_yv", {3'b000, y_valid}, 4'b0001);
        chk("first_y0", {3'b000, y}, 4'b0000);
        din = 4'b0010;
        #1;
        chk("first_y1", {3'b000, y}, 4'b0001);

        // fairness on the HOLD_MAX=1 instance
        din = 4'b0101;
        restart(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", gnt1, 4'(1 << (i % 4)));
            chk("rr_sel", {2'b00, s01, s11}, 4'(i % 4));
            chk("rr_yv", {3'b000, yv1}, 4'b0001);
            chk("rr_y", {3'b000, y1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end

        // hold limit on the HOLD_MAX=4 instance
        din = 4'b0001;
        restart(4'b0101, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold_gnt", gnt, (i >= 4 && i < 8) ? 4'b0100 : 4'b0001);
            chk("hold_y", {3'b000, y}, (i >= 4 && i < 8) ? 4'b0000 : 4'b0001);
        end

        // stall with cnt=1 on source 3, then source 0 arrives and must wait
        restart(4'b1000, 1'b1);
        tick();
        chk("stall_g0", gnt, 4'b1000);
        tick();
        chk("stall_g1", gnt, 4'b1000);
        out_ready = 1'b0;
        req       = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stall_gnt", gnt, 4'b1000);
            chk("stall_sel", {2'b00, s0, s1}, 4'b0011);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_xa", gnt, 4'b1000);
        tick();
        chk("stall_xb", gnt, 4'b1000);
        tick();
        chk("stall_rel", gnt, 4'b0001);

        // early drop on source 1 after two transfers
        restart(4'b0010, 1'b1);
        tick();
        chk("drop_g0", gnt, 4'b0010);
        tick();
        tick();
        chk("drop_g2", gnt, 4'b0010);
        req = 4'b0000;
        #1;
        chk("drop_yv", {3'b000, y_valid}, 4'b0000);
        tick();
        chk("drop_idle", gnt, 4'b0000);
        chk("drop_sel", {2'b00, s0, s1}, 4'b0001);
        req = 4'b0110;
        tick();
        chk("drop_ptr", gnt, 4'b0100);
        chk("drop_psel", {2'b00, s0, s1}, 4'b0010);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 4'b0000);
        chk("arst_sel", {2'b00, s0, s1}, 4'b0000);
        chk("arst_yv", {3'b000, y_valid}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 single-bit multiplexer among four requesters.
- Each cycle it selects exactly one granted requester and drives the mux select pair (s0, s1) for it. It then presents the selected bit downstream with a valid/ready handshake.
- Sits between four 1-bit sources and a single 1-bit consumer; the combinational mux is instantiated inside.

Parameters:
- HOLD_MAX, 4: maximum accepted transfers per grant before a forced release. Legal range 1..15.
- CNT_W, 4: width of the transfer counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per source; req[i] held high while source i has data.
- din  input  4  data bit per source; din[i] goes to mux input i.
- out_ready  input  1  consumer accepts y this cycle.
- gnt  output  4  one-hot grant, registered.
- s0  output  1  mux select MSB, registered.
- s1  output  1  mux select LSB, registered.
- y  output  1  selected data bit; combinational from din via s0/s1.
- y_valid  output  1  y is valid this cycle.

Behaviour:
- Select encoding (s0,s1):
  - 00 selects i0.
  - 01 selects i1.
  - 10 selects i2.
  - 11 selects i3.
  - Granted index g gives s0 = g[1], s1 = g[0].
- Reset (async, rst_n=0):
  - state=IDLE, gnt=0000, s0=0, s1=0, ptr=0, cnt=0, y_valid=0.
  - y then equals din[0].
- States:
  - IDLE: no grant.
  - GRANT: gnt one-hot, y_valid = req[g].
- Arbitration function:
  - Scan req starting at index ptr and ascending modulo 4.
  - The first set bit wins.
- IDLE -> GRANT:
  - Taken at the edge where any req bit is 1.
  - gnt, s0, s1 are loaded at that same edge; cnt=0.
  - Latency from req sampled high to gnt visible: 1 cycle.
- Transfer:
  - A transfer occurs when y_valid & out_ready.
  - Each transfer increments cnt.
  - With out_ready=0, cnt holds and the grant holds (stall; no timeout).
- Release condition in GRANT, either of:
  - (a) req[g]=0, or
  - (b) a transfer occurs with cnt == HOLD_MAX-1.
- On release:
  - ptr <= (g+1) mod 4.
  - cnt <= 0.
  - If any other request is pending, re-arbitrate in the same cycle using the new ptr, with req[g] masked for case (b) only. The new grant appears at the next edge with no idle bubble.
  - Otherwise go to IDLE with gnt=0000. s0/s1 keep their last value.
- Case (b) with only requester g active: the grant is reissued to g at the next edge. Self-wrap is allowed, with no bubble.
- Case (a) while out_ready=1: no transfer in that cycle, since y_valid=0.
- Requests that arrive while GRANT is active wait; a grant is never preempted before release.
- s0/s1 change only at grant edges. y follows din of the granted source combinationally.
- gnt is always one-hot or zero. s0/s1 always match the index of gnt when gnt≠0.
- Reset mid-grant: state returns to IDLE immediately (asynchronous). No partial transfer is counted.
- Sizing check: for HOLD_MAX=15 with CNT_W=4, cnt reaches 14 before release and never wraps.

Decomposition:
- Shared package mux4_arb_pkg:
  - localparam N_REQ=4, SEL_W=2.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - Function rr_pick(req, ptr) returning the index plus a found flag.
- Sub-module mux4_sel: purely combinational 4:1 mux with ports s0, s1, i0..i3, y, using the select encoding above. Instantiated once.

Test Plan:
- Reset then idle: rst_n=0, req=1010 -> gnt=0000, s0s1=00, y_valid=0. Deassert reset, next edge -> gnt=0010, s0s1=01, y_valid=1.
- Round-robin fairness: req=1111, out_ready=1, HOLD_MAX=1 -> grants rotate 0001, 0010, 0100, 1000, 0001 on consecutive cycles. s0s1 goes 00, 01, 10, 11, 00 with no bubble.
- Hold limit: req=0101 steady, out_ready=1, HOLD_MAX=4 -> gnt=0001 for 4 transfers, then 0100 for 4, then 0001. y tracks din[0], then din[2].
- Stall: grant on source 3 with cnt=1, out_ready=0 for 6 cycles -> gnt=1000 and s0s1=11 held, cnt stays 1. Release occurs only after 3 more accepted transfers.
- Early drop: source 1 granted, req[1] falls after 2 transfers with req=0000 -> IDLE next edge with gnt=0000, ptr=2. A later req=0110 -> grant 0100, not 0010.
- Async reset mid-grant: pulse rst_n low between edges while gnt=0100 -> gnt=0000, s0s1=00, y_valid=0 immediately, without waiting for a clock edge.
